// File: rtl/dispatch_unit.sv
// Dispatch/rename stage for a Tomasulo-style core: allocates reservation stations,
// renames sources through a 4-entry register status table and retires tags on
// result broadcasts. Define DUAL_ISSUE_EN to enable the second issue slot.
module dispatch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst1,
  input  logic        inst1_valid,
  input  logic [31:0] inst2,
  input  logic        inst2_valid,
  output logic        inst1_take,
  output logic        inst2_take,
  input  logic [39:0] addbus,
  input  logic [39:0] multbus,
  input  logic [39:0] loadbus,
  input  logic [1:0]  store_done,
  output logic [39:0] instbus1,
  output logic [39:0] instbus2
);

  localparam logic [7:0] OpLoad  = 8'h01;
  localparam logic [7:0] OpStore = 8'h02;
  localparam logic [7:0] OpAdd   = 8'h03;
  localparam logic [7:0] OpMulti = 8'h04;

  // Station bit order: A0-A2 [2:0], M0-M1 [4:3], LD0-LD1 [6:5], ST0-ST1 [8:7]
  function automatic logic [8:0] class_mask(input logic [7:0] op);
    case (op)
      OpAdd:   return 9'b0_0000_0111;
      OpMulti: return 9'b0_0001_1000;
      OpLoad:  return 9'b0_0110_0000;
      OpStore: return 9'b1_1000_0000;
      default: return 9'b0_0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] station_tag(input int unsigned idx);
    if (idx < 3)      return 8'h20 + 8'(idx);
    else if (idx < 5) return 8'h30 + 8'(idx - 3);
    else if (idx < 7) return 8'h40 + 8'(idx - 5);
    else              return 8'h50 + 8'(idx - 7);
  endfunction

  function automatic logic [7:0] oh_tag(input logic [8:0] oh);
    logic [7:0] t;
    t = 8'h00;
    for (int unsigned i = 0; i < 9; i++) begin
      if (oh[i]) t |= station_tag(i);
    end
    return t;
  endfunction

  function automatic logic [8:0] lowest_set(input logic [8:0] m);
    return m & (~m + 9'd1);
  endfunction

  function automatic logic is_reg(input logic [7:0] code);
    return code[7:2] == 6'b000100;
  endfunction

  function automatic logic writes_rst(input logic [7:0] op);
    return op inside {OpLoad, OpAdd, OpMulti};
  endfunction

  function automatic logic [7:0] rename(input logic [7:0] src, input logic [3:0][7:0] tbl);
    if (is_reg(src) && tbl[src[1:0]] != 8'h00) return tbl[src[1:0]];
    return src;
  endfunction

  logic [8:0]       busy_q, busy_d;
  logic [3:0][7:0]  rst_q, rst_d;
  logic [39:0]      instbus1_q, instbus1_d;
  logic [8:0]       mask1, alloc1, alloc2, hit;
  logic [7:0]       tag1, tag2, src1a, src1b;
  logic             wr1, wr2;

  // Slot 1: class lookup, station pick and source rename from the current table
  always_comb begin
    mask1      = class_mask(inst1[31:24]);
    alloc1     = lowest_set(~busy_q & mask1);
    tag1       = oh_tag(alloc1);
    inst1_take = rst_n && inst1_valid && (mask1 == 9'd0 || alloc1 != 9'd0);
    wr1        = inst1_take && writes_rst(inst1[31:24]) && is_reg(inst1[7:0]);
    src1a      = rename(inst1[23:16], rst_q);
    src1b      = rename(inst1[15:8], rst_q);
    instbus1_d = 40'h0;
    if (inst1_take && mask1 != 9'd0) begin
      instbus1_d = {tag1, inst1[31:24], src1a, src1b, inst1[7:0]};
    end
  end

`ifdef DUAL_ISSUE_EN
  logic [8:0]  mask2;
  logic [7:0]  src2a, src2b;
  logic [39:0] instbus2_q, instbus2_d;

  // Slot 2: sees slot 1's allocation and forwards its new tag to dependent sources
  always_comb begin
    mask2      = class_mask(inst2[31:24]);
    alloc2     = lowest_set(~(busy_q | alloc1) & mask2);
    tag2       = oh_tag(alloc2);
    inst2_take = inst1_take && inst2_valid && (mask2 == 9'd0 || alloc2 != 9'd0);
    wr2        = inst2_take && writes_rst(inst2[31:24]) && is_reg(inst2[7:0]);
    src2a      = rename(inst2[23:16], rst_q);
    src2b      = rename(inst2[15:8], rst_q);
    if (wr1 && inst2[23:16] == inst1[7:0]) src2a = tag1;
    if (wr1 && inst2[15:8] == inst1[7:0])  src2b = tag1;
    instbus2_d = 40'h0;
    if (inst2_take && mask2 != 9'd0) begin
      instbus2_d = {tag2, inst2[31:24], src2a, src2b, inst2[7:0]};
    end
  end

  // Slot 2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instbus2_q <= 40'h0;
    else        instbus2_q <= instbus2_d;
  end

  assign instbus2 = instbus2_q;
`else
  logic unused_slot2;
  assign unused_slot2 = ^{inst2, inst2_valid};
  assign alloc2     = 9'd0;
  assign tag2       = 8'h00;
  assign wr2        = 1'b0;
  assign inst2_take = 1'b0;
  assign instbus2   = 40'h0;
`endif

  logic unused_values;
  assign unused_values = ^{addbus[31:0], multbus[31:0], loadbus[31:0]};

  // Broadcast retirement plus dispatch allocation; dispatch writes land last so they win
  always_comb begin
    hit = 9'd0;
    for (int unsigned i = 0; i < 3; i++) hit[i] = busy_q[i] && (addbus[39:32] == station_tag(i));
    for (int unsigned i = 3; i < 5; i++) hit[i] = busy_q[i] && (multbus[39:32] == station_tag(i));
    for (int unsigned i = 5; i < 7; i++) hit[i] = busy_q[i] && (loadbus[39:32] == station_tag(i));
    hit[7] = busy_q[7] && store_done[0];
    hit[8] = busy_q[8] && store_done[1];

    busy_d = busy_q & ~hit;
    if (inst1_take) busy_d = busy_d | alloc1;
    if (inst2_take) busy_d = busy_d | alloc2;

    rst_d = rst_q;
    for (int unsigned j = 0; j < 4; j++) begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (hit[i] && rst_q[j] == station_tag(i)) rst_d[j] = 8'h00;
      end
    end
    if (wr1) rst_d[inst1[1:0]] = tag1;
    if (wr2) rst_d[inst2[1:0]] = tag2;
  end

  // State and slot 1 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 9'd0;
      rst_q      <= '0;
      instbus1_q <= 40'h0;
    end else begin
      busy_q     <= busy_d;
      rst_q      <= rst_d;
      instbus1_q <= instbus1_d;
    end
  end

  assign instbus1 = instbus1_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit; dual-issue checks follow DUAL_ISSUE_EN.
module tb_dispatch_unit;

  localparam logic [7:0] OpLoad  = 8'h01;
  localparam logic [7:0] OpStore = 8'h02;
  localparam logic [7:0] OpAdd   = 8'h03;
  localparam logic [7:0] OpMulti = 8'h04;
  localparam logic [7:0] R0 = 8'h10;
  localparam logic [7:0] R1 = 8'h11;
  localparam logic [7:0] R2 = 8'h12;
  localparam logic [7:0] R3 = 8'h13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] inst1, inst2;
  logic        inst1_valid, inst2_valid;
  logic        inst1_take, inst2_take;
  logic [39:0] addbus, multbus, loadbus;
  logic [1:0]  store_done;
  logic [39:0] instbus1, instbus2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dispatch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst1       (inst1),
    .inst1_valid (inst1_valid),
    .inst2       (inst2),
    .inst2_valid (inst2_valid),
    .inst1_take  (inst1_take),
    .inst2_take  (inst2_take),
    .addbus      (addbus),
    .multbus     (multbus),
    .loadbus     (loadbus),
    .store_done  (store_done),
    .instbus1    (instbus1),
    .instbus2    (instbus2)
  );

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] s1,
                                     input logic [7:0] s2, input logic [7:0] d);
    return {op, s1, s2, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst1_valid = 1'b0;
    inst2_valid = 1'b0;
    addbus      = 40'h0;
    multbus     = 40'h0;
    loadbus     = 40'h0;
    store_done  = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  // Single instruction on slot 1: expect acceptance, then the renamed bus word
  task automatic issue1(input string tag, input logic [31:0] i, input logic [39:0] exp_bus);
    inst1       = i;
    inst1_valid = 1'b1;
    inst2_valid = 1'b0;
    #1;
    check_eq({tag, "_take"}, 40'(inst1_take), 40'h1);
    tick();
    idle();
    check_eq({tag, "_bus"}, instbus1, exp_bus);
  endtask

  initial begin
    inst1 = mk(OpAdd, R1, R2, R0);
    inst2 = mk(OpAdd, R1, R2, R1);
    inst1_valid = 1'b1;
    inst2_valid = 1'b1;
    addbus = 40'h0; multbus = 40'h0; loadbus = 40'h0; store_done = 2'b00;
    rst_n = 1'b0;
    #2;
    check_eq("rst_take1", 40'(inst1_take), 40'h0);
    check_eq("rst_take2", 40'(inst2_take), 40'h0);
    check_eq("rst_bus1", instbus1, 40'h0);
    check_eq("rst_bus2", instbus2, 40'h0);
    tick();
    tick();
    check_eq("rst_bus1_clocked", instbus1, 40'h0);
    idle();
    rst_n = 1'b1;
    tick();

    // First ADD after reset, bus valid for exactly one cycle
    issue1("add_first", mk(OpAdd, R1, R2, R0), 40'h20_03_11_12_10);
    check_eq("add_first_rst0", 40'(dut.rst_q[0]), 40'h20);
    tick();
    check_eq("add_first_one_cycle", instbus1, 40'h0);

    // Unknown opcode: accepted, no bus word, no allocation
    do_reset();
    inst1 = 32'hFF11_1210;
    inst1_valid = 1'b1;
    #1;
    check_eq("nop_take", 40'(inst1_take), 40'h1);
    tick();
    idle();
    check_eq("nop_bus", instbus1, 40'h0);
    issue1("after_nop", mk(OpAdd, R3, R3, R3), 40'h20_03_13_13_13);

`ifdef DUAL_ISSUE_EN
    // Dependent pair
    do_reset();
    inst1 = mk(OpAdd, R1, R2, R3);
    inst2 = mk(OpMulti, R3, R0, R1);
    inst1_valid = 1'b1;
    inst2_valid = 1'b1;
    #1;
    check_eq("pair_take1", 40'(inst1_take), 40'h1);
    check_eq("pair_take2", 40'(inst2_take), 40'h1);
    tick();
    idle();
    check_eq("pair_bus1", instbus1, 40'h20_03_11_12_13);
    check_eq("pair_bus2", instbus2, 40'h30_04_20_10_11);
    check_eq("pair_rst3", 40'(dut.rst_q[3]), 40'h20);
    check_eq("pair_rst1", 40'(dut.rst_q[1]), 40'h30);

    // Same destination: younger tag wins
    do_reset();
    inst1 = mk(OpAdd, R1, R2, R0);
    inst2 = mk(OpMulti, R1, R2, R0);
    inst1_valid = 1'b1;
    inst2_valid = 1'b1;
    tick();
    idle();
    check_eq("coll_bus2", instbus2, 40'h30_04_11_12_10);
    check_eq("coll_rst0", 40'(dut.rst_q[0]), 40'h30);

    // Only one ADD station left for an ADD pair
    do_reset();
    inst1 = mk(OpAdd, R1, R1, R1);
    inst2 = mk(OpAdd, R2, R2, R2);
    inst1_valid = 1'b1;
    inst2_valid = 1'b1;
    tick();
    check_eq("two_add_bus2", instbus2, 40'h21_03_12_12_12);
    inst1 = mk(OpAdd, R0, R0, R0);
    inst2 = mk(OpAdd, R3, R3, R3);
    #1;
    check_eq("last_a_take1", 40'(inst1_take), 40'h1);
    check_eq("last_a_take2", 40'(inst2_take), 40'h0);
    tick();
    idle();
    check_eq("last_a_bus1", instbus1, 40'h22_03_10_10_10);
    check_eq("last_a_bus2", instbus2, 40'h0);
`else
    // Slot 2 is inert in single-issue builds
    do_reset();
    inst1 = mk(OpAdd, R1, R2, R3);
    inst2 = mk(OpMulti, R3, R0, R1);
    inst1_valid = 1'b1;
    inst2_valid = 1'b1;
    #1;
    check_eq("single_take1", 40'(inst1_take), 40'h1);
    check_eq("single_take2", 40'(inst2_take), 40'h0);
    tick();
    idle();
    check_eq("single_bus1", instbus1, 40'h20_03_11_12_13);
    check_eq("single_bus2", instbus2, 40'h0);
    check_eq("single_rst1", 40'(dut.rst_q[1]), 40'h0);
    check_eq("single_rst3", 40'(dut.rst_q[3]), 40'h20);
`endif

    // Fill A0-A2, stall the fourth ADD until A1 retires
    do_reset();
    issue1("fill_a0", mk(OpAdd, R1, R2, R0), 40'h20_03_11_12_10);
    issue1("fill_a1", mk(OpAdd, R0, R1, R1), 40'h21_03_20_11_11);
    issue1("fill_a2", mk(OpAdd, R1, R1, R2), 40'h22_03_21_21_12);
    inst1 = mk(OpAdd, R2, R3, R3);
    inst1_valid = 1'b1;
    #1;
    check_eq("full_take", 40'(inst1_take), 40'h0);
    tick();
    check_eq("full_bus", instbus1, 40'h0);
    addbus = {8'h21, 32'h0000_0005};
    #1;
    check_eq("free_same_cycle_take", 40'(inst1_take), 40'h0);
    tick();
    addbus = 40'h0;
    #1;
    check_eq("freed_take", 40'(inst1_take), 40'h1);
    check_eq("freed_rst1", 40'(dut.rst_q[1]), 40'h0);
    tick();
    idle();
    check_eq("freed_bus", instbus1, 40'h21_03_22_13_13);
    check_eq("freed_rst3", 40'(dut.rst_q[3]), 40'h21);

    // LOAD, STORE and their retirement paths
    do_reset();
    issue1("ld", mk(OpLoad, R0, R1, R2), 40'h40_01_10_11_12);
    check_eq("ld_rst2", 40'(dut.rst_q[2]), 40'h40);
    issue1("st", mk(OpStore, R2, R1, R0), 40'h50_02_40_11_10);
    check_eq("st_rst0", 40'(dut.rst_q[0]), 40'h0);
    store_done = 2'b01;
    tick();
    store_done = 2'b00;
    issue1("st_reuse", mk(OpStore, R3, R3, R3), 40'h50_02_13_13_13);
    loadbus = {8'h40, 32'h0000_1234};
    tick();
    loadbus = 40'h0;
    check_eq("ld_rst2_clear", 40'(dut.rst_q[2]), 40'h0);
    issue1("add_r2", mk(OpAdd, R2, R1, R0), 40'h20_03_12_11_10);

    // Broadcast and rename in the same cycle
    do_reset();
    issue1("race_a0", mk(OpAdd, R1, R2, R0), 40'h20_03_11_12_10);
    addbus = {8'h20, 32'h0000_0007};
    inst1 = mk(OpAdd, R0, R1, R0);
    inst1_valid = 1'b1;
    #1;
    check_eq("race_take", 40'(inst1_take), 40'h1);
    tick();
    idle();
    check_eq("race_bus", instbus1, 40'h21_03_20_11_10);
    check_eq("race_rst0", 40'(dut.rst_q[0]), 40'h21);
    issue1("race_a0_reuse", mk(OpAdd, R3, R3, R3), 40'h20_03_13_13_13);

    // Reset mid-stream with an accepted instruction in flight
    do_reset();
    issue1("mid_a0", mk(OpAdd, R1, R2, R0), 40'h20_03_11_12_10);
    issue1("mid_a1", mk(OpAdd, R1, R2, R1), 40'h21_03_11_12_11);
    inst1 = mk(OpAdd, R1, R2, R2);
    inst1_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_bus1_async", instbus1, 40'h0);
    check_eq("mid_bus2_async", instbus2, 40'h0);
    check_eq("mid_take1_async", 40'(inst1_take), 40'h0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    check_eq("mid_dropped", instbus1, 40'h0);
    check_eq("mid_busy_free", 40'(dut.busy_q), 40'h0);
    issue1("mid_post", mk(OpAdd, R1, R2, R0), 40'h20_03_11_12_10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have clocking fixed as one clock and an asynchronous, active-low reset.
REQ-002 SHALL have ports `clk`, input, 1 bit, rising-edge clock.
REQ-003 SHALL have ports `rst_n`, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have ports `inst1`, input, 32 bits: {opcode[31:24], src1[23:16], src2[15:8], dest[7:0]}, with register codes 8'h10-8'h13.
REQ-005 SHALL have ports `inst1_valid`, input, 1 bit, `inst1` present.
REQ-006 SHALL have ports `inst2`, input, 32 bits, the younger instruction, same format as `inst1`.
REQ-007 SHALL have ports `inst2_valid`, input, 1 bit, meaningful only while `inst1_valid` is high.
REQ-008 SHALL have ports `inst1_take`, output, 1 bit, combinational, `inst1` accepted this cycle.
REQ-009 SHALL have ports `inst2_take`, output, 1 bit, combinational, `inst2` accepted this cycle.
REQ-010 SHALL have ports `addbus`, `multbus`, `loadbus`, input, 40 bits each, result broadcast {tag[39:32], value}, 40'hz or tag 0 when idle.
REQ-011 SHALL have ports `store_done`, input, 2 bits, one-cycle pulse freeing ST0/ST1.
REQ-012 SHALL have ports `instbus1`, `instbus2`, output, 40 bits each, registered: {rs_tag, opcode, src1', src2', dest}.

Function
REQ-013 SHALL use these encodings: opcodes LOAD 01, STORE 02, ADD 03, MULTI 04; stations A0-A2 20-22, M0-M1 30-31, LD0-LD1 40-41, ST0-ST1 50-51.
REQ-014 SHALL keep a busy bit for each of the 9 stations and a 4-entry register status table (RST) of 8-bit tags, where 0 means the value is in the register file.
REQ-015 SHALL allocate, for an accepted instruction, the lowest-index free station of its class (ADD->A, MULTI->M, LOAD->LD, STORE->ST) and set its busy bit at the clock edge.
REQ-016 SHALL rename each source: output the register code when its RST entry is 0, otherwise output the RST tag.
REQ-017 SHALL write the allocated station tag into RST[dest] for ADD, MULTI and LOAD; STORE leaves the RST unchanged and passes `dest` through unchanged.
REQ-018 SHALL assert `inst1_take` when `inst1_valid` is high and a station of the needed class is free.
REQ-019 SHALL assert `inst2_take` only when `inst1_take`, `inst2_valid` and a second free station of the needed class (after `inst1`'s allocation) are all present; issue is in order and never bypasses `inst1`.
REQ-020 SHALL resolve intra-pair dependence: an `inst2` source equal to `inst1`'s dest (non-STORE) uses `inst1`'s new tag.
REQ-021 SHALL resolve intra-pair dest collision: when both write the same dest, `inst2`'s tag is written to the RST.
REQ-022 SHALL treat an unknown opcode as a NOP: take asserted, no allocation, bus value 0.
REQ-023 SHALL, on the cycle after acceptance, drive each `instbus` with the renamed instruction for exactly one cycle, and 40'h0 in all other cycles.
REQ-024 SHALL, at a broadcast whose bus tag matches a busy A/M/LD station, clear that station's busy bit and clear every RST entry holding that tag; a `store_done` bit frees its ST station.
REQ-025 SHALL make a freed station available from the next cycle; a same-cycle RST write from dispatch overrides a broadcast clear of the same entry.
REQ-026 SHALL treat a broadcast that arrives in the same cycle as a rename as not seen by that rename: the tag is still emitted.

Reset
REQ-027 SHALL, while `rst_n` is low, asynchronously clear all busy bits and RST entries, force `instbus1` and `instbus2` to 40'h0, and force `inst1_take` and `inst2_take` to 0.
REQ-028 SHALL drop any instruction that was in flight when reset asserted, with no output afterwards.

Configuration
REQ-029 SHALL, with DUAL_ISSUE_EN defined, provide dual issue as specified above.
REQ-030 SHALL, without DUAL_ISSUE_EN, hold `inst2_take` at 0 and `instbus2` at 40'h0, with no slot-2 logic.

Verification
REQ-031 SHALL verify ADD R1,R2->R0 after reset: the next cycle gives `instbus1` = 40'h20_03_11_12_10 and RST[0] = 20.
REQ-032 SHALL verify pair ADD R1,R2->R3 plus MULTI R3,R0->R1: `instbus1` = 20_03_11_12_13 and `instbus2` = 30_04_20_10_11.
REQ-033 SHALL verify a fourth ADD with A0-A2 busy: `inst1_take` = 0 until `addbus` tag 21 arrives, then the next cycle takes it into A1.
REQ-034 SHALL verify `loadbus` tag 40 with RST[2] = 40: RST[2] clears, and a later ADD R2 reads source code 12.
REQ-035 SHALL verify same-cycle `addbus` tag 20 and an ADD with dest R0: RST[0] holds the new tag, not 0.
REQ-036 SHALL verify `rst_n` low mid-stream: busses are 0 immediately, and all stations are free after release.
